// File: rtl/feature_fwft_replay.sv
// feature_fwft_replay
// -------------------
// First-word-fall-through frame buffer for the conv datapath. One frame of
// DEPTH words (CHANNELS lanes of DATA_W bits each) is written once. It is then
// read out PASSES times, once per filter group. The buffer is released for the
// next frame only after the last word of the final pass is consumed. Pass 0 may
// read while the frame is still filling.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active low
//   wr_en/wr_data  write request and word; accepted when wr_ready is high
//   wr_ready       frame not yet full (wr_ptr < DEPTH)
//   rd_en          consume the word currently shown on rd_data
//   rd_valid       rd_data holds a written, unread word of this pass
//   rd_data        word at the read pointer, combinational from storage
//   rd_last        rd_data is word DEPTH-1 of the current pass
//   rd_frame_done  rd_last on the final pass
//   pass_idx       current read pass, 0..PASSES-1
//   fill_count     words written into the current frame, 0..DEPTH
//   err_overflow   sticky: write attempted while wr_ready was low
//   err_underflow  sticky: read attempted while rd_valid was low
module feature_fwft_replay #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 1,
    parameter int DEPTH    = 729,
    parameter int PASSES   = 1,
    localparam int W       = CHANNELS * DATA_W,
    localparam int AW      = $clog2(DEPTH + 1),
    localparam int PW      = $clog2(PASSES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    output logic          wr_ready,
    input  logic          rd_en,
    output logic          rd_valid,
    output logic [W-1:0]  rd_data,
    output logic          rd_last,
    output logic          rd_frame_done,
    output logic [PW-1:0] pass_idx,
    output logic [AW-1:0] fill_count,
    output logic          err_overflow,
    output logic          err_underflow
);

    // Storage index width. A pointer that addresses storage is always below
    // DEPTH, so its low IW bits are enough to select the word.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] PTR_FULL  = AW'(DEPTH);
    localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
    localparam logic [PW-1:0] PASS_ZERO = PW'(0);
    localparam logic [PW-1:0] PASS_ONE  = PW'(1);
    localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);

    logic [W-1:0]  mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] pass_q, pass_d;
    logic          err_ov_q, err_ov_d;
    logic          err_un_q, err_un_d;

    logic          wr_ready_s;
    logic          rd_valid_s;
    logic          rd_last_s;
    logic          frame_done_s;
    logic          wr_acc_s;
    logic          rd_acc_s;

    // Status decode from the pointers. The release cycle always has
    // wr_ptr == DEPTH, so a write in that cycle is rejected here.
    always_comb begin
        wr_ready_s   = (wr_ptr_q < PTR_FULL);
        rd_valid_s   = (rd_ptr_q < wr_ptr_q);
        rd_last_s    = rd_valid_s & (rd_ptr_q == PTR_LAST);
        frame_done_s = rd_last_s & (pass_q == PASS_LAST);
        wr_acc_s     = wr_en & wr_ready_s;
        rd_acc_s     = rd_en & rd_valid_s;
    end

    // Pointer, pass and error next-state logic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pass_d   = pass_q;
        err_ov_d = err_ov_q | (wr_en & ~wr_ready_s);
        err_un_d = err_un_q | (rd_en & ~rd_valid_s);

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            if (frame_done_s) begin
                // Final pass finished: hand the buffer back to the writer.
                wr_ptr_d = PTR_ZERO;
                rd_ptr_d = PTR_ZERO;
                pass_d   = PASS_ZERO;
            end else if (rd_last_s) begin
                // Replay the same frame for the next filter group.
                rd_ptr_d = PTR_ZERO;
                pass_d   = pass_q + PASS_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            pass_q   <= PASS_ZERO;
            err_ov_q <= 1'b0;
            err_un_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            pass_q   <= pass_d;
            err_ov_q <= err_ov_d;
            err_un_q <= err_un_d;
        end
    end

    // Frame storage; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem[wr_ptr_q[IW-1:0]] <= wr_data;
        end
    end

    // Output mapping. rd_data falls through from storage with no read register.
    always_comb begin
        wr_ready      = wr_ready_s;
        rd_valid      = rd_valid_s;
        rd_data       = mem[rd_ptr_q[IW-1:0]];
        rd_last       = rd_last_s;
        rd_frame_done = frame_done_s;
        pass_idx      = pass_q;
        fill_count    = wr_ptr_q;
        err_overflow  = err_ov_q;
        err_underflow = err_un_q;
    end

endmodule

// File: tb/tb_feature_fwft_replay.sv
// Self-checking bench for feature_fwft_replay (DEPTH=4, CHANNELS=2, PASSES=2).
// A frame-level model (queue of written words, count of words consumed in the
// current pass, pass number) predicts every output; a compare process checks
// the DUT against it on each falling edge. Directed scenarios add literal
// expectations, then a randomized phase exercises mixed traffic and resets.
module tb_feature_fwft_replay;

    localparam int DATA_W   = 8;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 4;
    localparam int PASSES   = 2;
    localparam int W        = DATA_W * CHANNELS;
    localparam int AW       = $clog2(DEPTH + 1);
    localparam int PW       = $clog2(PASSES + 1);

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [W-1:0]  wr_data;
    logic          wr_ready;
    logic          rd_en;
    logic          rd_valid;
    logic [W-1:0]  rd_data;
    logic          rd_last;
    logic          rd_frame_done;
    logic [PW-1:0] pass_idx;
    logic [AW-1:0] fill_count;
    logic          err_overflow;
    logic          err_underflow;

    feature_fwft_replay #(
        .DATA_W(DATA_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .PASSES(PASSES)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_last(rd_last), .rd_frame_done(rd_frame_done),
        .pass_idx(pass_idx), .fill_count(fill_count),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [W-1:0] frame[$];
    int           consumed = 0;
    int           m_pass   = 0;
    bit           m_ov     = 1'b0;
    bit           m_un     = 1'b0;
    bit           model_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return frame.size() < DEPTH;
    endfunction

    function automatic bit m_valid();
        return consumed < frame.size();
    endfunction

    // One clock: drive inputs, advance the model at the rising edge, and
    // return just after the falling edge so outputs have settled.
    task automatic step(input logic r, input logic we, input logic [W-1:0] wd, input logic re);
        bit v, rdy, fire;
        rst = r; wr_en = we; wr_data = wd; rd_en = re;
        @(posedge clk);
        v   = m_valid();
        rdy = m_ready();
        if (!r) begin
            frame.delete();
            consumed = 0; m_pass = 0; m_ov = 1'b0; m_un = 1'b0;
            model_on = 1'b1;
        end else begin
            if (re && !v)   m_un = 1'b1;
            if (we && !rdy) m_ov = 1'b1;
            fire = re && v;
            if (fire) begin
                if (consumed == DEPTH - 1) begin
                    consumed = 0;
                    if (m_pass == PASSES - 1) begin
                        m_pass = 0;
                        frame.delete();
                    end else begin
                        m_pass++;
                    end
                end else begin
                    consumed++;
                end
            end
            if (we && rdy) frame.push_back(wd);
        end
        @(negedge clk);
        #1;
    endtask

    // Compare process: DUT outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                chk("wr_ready", 32'(wr_ready), 32'(m_ready()));
                chk("rd_valid", 32'(rd_valid), 32'(m_valid()));
                if (m_valid()) chk("rd_data", 32'(rd_data), 32'(frame[consumed]));
                chk("rd_last", 32'(rd_last), 32'(m_valid() && consumed == DEPTH - 1));
                chk("rd_frame_done", 32'(rd_frame_done),
                    32'(m_valid() && consumed == DEPTH - 1 && m_pass == PASSES - 1));
                chk("pass_idx", 32'(pass_idx), 32'(m_pass));
                chk("fill_count", 32'(fill_count), 32'(frame.size()));
                chk("err_overflow", 32'(err_overflow), 32'(m_ov));
                chk("err_underflow", 32'(err_underflow), 32'(m_un));
            end
        end
    end

    logic [W-1:0] exp_seq [8];
    int           wp, rp;

    initial begin
        exp_seq[0] = 16'h0101; exp_seq[1] = 16'h0202; exp_seq[2] = 16'h0303; exp_seq[3] = 16'h0404;
        exp_seq[4] = 16'h0101; exp_seq[5] = 16'h0202; exp_seq[6] = 16'h0303; exp_seq[7] = 16'h0404;
        rst = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
        @(negedge clk);

        // Reset held two cycles
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_fill", 32'(fill_count), 32'd0);
        chk("rst_errs", 32'({err_overflow, err_underflow}), 32'd0);

        // Fill four words, then one blocked write
        step(1'b1, 1'b1, 16'h0101, 1'b0);
        step(1'b1, 1'b1, 16'h0202, 1'b0);
        step(1'b1, 1'b1, 16'h0303, 1'b0);
        step(1'b1, 1'b1, 16'h0404, 1'b0);
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        step(1'b1, 1'b1, 16'h0505, 1'b0);
        chk("bp_err_overflow", 32'(err_overflow), 32'd1);
        chk("bp_fill", 32'(fill_count), 32'd4);

        // Replay two passes with rd_en held
        for (int i = 0; i < 8; i++) begin
            chk("replay_data", 32'(rd_data), 32'(exp_seq[i]));
            chk("replay_pass", 32'(pass_idx), 32'(i / 4));
            chk("replay_last", 32'(rd_last), 32'(i % 4 == 3));
            chk("replay_done", 32'(rd_frame_done), 32'(i == 7));
            step(1'b1, 1'b0, 16'h0000, 1'b1);
        end
        chk("release_wr_ready", 32'(wr_ready), 32'd1);
        chk("release_rd_valid", 32'(rd_valid), 32'd0);

        // FWFT latency and last-visible-word consumption
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b1, 16'h00AA, 1'b0);
        chk("fwft_valid", 32'(rd_valid), 32'd1);
        chk("fwft_data", 32'(rd_data), 32'h00AA);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        chk("fwft_drained", 32'(rd_valid), 32'd0);

        // Underflow on an empty buffer
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        chk("uf_flag", 32'(err_underflow), 32'd1);
        step(1'b1, 1'b1, 16'h1111, 1'b0);
        chk("uf_first_word", 32'(rd_data), 32'h1111);

        // Mid-frame reset
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b1, 16'h2121, 1'b0);
        step(1'b1, 1'b1, 16'h2222, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("mid_fill", 32'(fill_count), 32'd0);
        chk("mid_pass", 32'(pass_idx), 32'd0);
        chk("mid_valid", 32'(rd_valid), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, W'(16'h3030 + i), 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0000, 1'b1);
        chk("mid_release", 32'(wr_ready), 32'd1);

        // Randomized mixed traffic
        wp = 50; rp = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                wp = $urandom_range(10, 95);
                rp = $urandom_range(10, 95);
            end
            if ($urandom_range(0, 249) == 0)
                step(1'b0, 1'b0, 16'h0000, 1'b0);
            else
                step(1'b1, $urandom_range(0, 99) < wp, W'($urandom), $urandom_range(0, 99) < rp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
